net_tx_arbiter: RTL and testbench
=================================

Name: net_tx_arbiter

Overview:
- Shares the single 64-bit network TX stream (the net_out interface into the network model/NIC) between N_PORTS packet sources.
- Arbitration is packet-level round-robin. A grant is held from a packet's first beat until its last beat.
- A token-bucket rate limiter, driven by the rlimit inc/period/size settings, gates beats onto the shared stream.
- Sits between the per-core/per-queue TX engines and the network port.

Parameters:
N_PORTS, 4, number of requesting TX sources (2..16)
DATA_W, 64, stream data width
KEEP_W, 8, byte-keep width (DATA_W/8)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
in_valid  in  N_PORTS  per-source beat valid
in_ready  out  N_PORTS  per-source beat accepted
in_data  in  N_PORTS*DATA_W  per-source data, source i at [i*DATA_W +: DATA_W]
in_keep  in  N_PORTS*KEEP_W  per-source byte keep
in_last  in  N_PORTS  per-source end-of-packet
out_valid  out  1  shared stream valid
out_ready  in  1  shared stream ready
out_data  out  DATA_W  shared stream data
out_keep  out  KEEP_W  shared stream keep
out_last  out  1  shared stream end-of-packet
rlimit_inc  in  8  tokens added per refill
rlimit_period  in  8  refill every rlimit_period+1 cycles
rlimit_size  in  8  bucket capacity; 0 disables the limiter
grant_id  out  $clog2(N_PORTS)  currently granted source (debug)
busy  out  1  high while in BURST

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0, tokens=0, period_cnt=0.
  - All in_ready=0, out_valid=0, busy=0.
- FSM states:
  - IDLE:
    - Pick the first i with in_valid[i]=1, searching from rr_ptr upward and wrapping modulo N_PORTS.
    - If one is found: register grant=i and go to BURST next cycle.
    - If none is found: stay in IDLE.
    - No beat is transferred in IDLE, so there is 1 bubble cycle per packet.
  - BURST:
    - Pass-through mux from the granted source.
    - On a handshake with out_last=1: go to IDLE and set rr_ptr=(grant+1) mod N_PORTS.
- Datapath and handshake:
  - can_send = (rlimit_size==0) || (tokens!=0).
  - out_valid = BURST && in_valid[grant] && can_send.
  - out_data, out_keep and out_last come from the granted source. They are 0 when not BURST.
  - in_ready[i] = BURST && (i==grant) && out_ready && can_send. All other sources see 0.
  - out_valid never depends on out_ready. There is no registered stage, so latency is 0 cycles.
  - A beat is transferred when out_valid && out_ready.
- Token bucket:
  - period_cnt counts 0..rlimit_period. When period_cnt==rlimit_period, refill=1 and period_cnt wraps to 0.
  - rlimit_period=0 therefore refills every cycle.
  - consume = beat transferred && rlimit_size!=0.
  - tokens_next = min(tokens - consume + (refill ? rlimit_inc : 0), rlimit_size). Compute in 9 bits so nothing wraps.
  - Refill and consume in the same cycle are both applied.
  - While rlimit_size==0: tokens are held at 0 and the limiter is bypassed.
  - A runtime decrease of rlimit_size clamps tokens on the next update.
- Boundary conditions:
  - A single-beat packet (last on the first beat) returns to IDLE after 1 transfer.
  - A source dropping in_valid mid-packet keeps the grant; the arbiter waits. Other sources stay stalled.
  - tokens==0 mid-packet stalls the packet; the grant is held.
  - With only one requester, it is re-granted after the 1-cycle IDLE bubble.
  - Reset mid-packet drops the grant immediately. The truncated packet is the upstream's responsibility.
- grant_id = grant; busy = (state==BURST).

Decomposition:
- Package net_tx_pkg:
  - arb_state_e {IDLE, BURST}
  - DATA_W and KEEP_W defaults
  - RL_W=8 and the rate-limit setting struct (inc, period, size)
- Sub-module net_token_bucket:
  - Ports: clock, reset, inc, period, size, consume.
  - Outputs: can_send, tokens.
  - Isolates the counter/saturation logic for separate unit test.
- Round-robin search stays inline as a function.

Test Plan:
- Limiter off (size=0), source 2 sends a 3-beat packet, out_ready=1 -> grant_id=2 the cycle after in_valid; 3 consecutive beats; data/keep/last match; back to IDLE, rr_ptr=3.
- All 4 sources valid with 2-beat packets, rr_ptr=0 -> packet order 0,1,2,3,0; one IDLE bubble between packets; no interleaving of beats.
- out_ready low for 5 cycles mid-packet, source holds data -> out_valid stays 1, in_ready stays 0, no beat lost or duplicated; grant held.
- inc=1, period=3, size=2, 8-beat packet -> first beat after 4 cycles; steady state 1 beat every 4 cycles; tokens never exceed 2.
- inc=200, size=255, period=0, tokens=250, refill and consume in the same cycle -> tokens saturate at 255, no wrap.
- reset driven low for 1 cycle mid-packet -> out_valid and in_ready drop immediately; tokens=0, state IDLE, rr_ptr=0 after release.

Source files
------------

// File: rtl/net_tx_pkg.sv
// Shared types and defaults for the network TX arbiter slice.
package net_tx_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int DATA_W_DEF = 64;
    localparam int KEEP_W_DEF = DATA_W_DEF / 8;
    localparam int RL_W       = 8;

    typedef struct packed {
        logic [RL_W-1:0] inc;
        logic [RL_W-1:0] period;
        logic [RL_W-1:0] size;
    } rl_cfg_t;

endpackage

// File: rtl/net_token_bucket.sv
// Token-bucket rate limiter: periodic refill, one token per transferred beat,
// saturating at the configured capacity. A capacity of 0 bypasses the limiter.
module net_token_bucket
    import net_tx_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic [RL_W-1:0] inc,
    input  logic [RL_W-1:0] period,
    input  logic [RL_W-1:0] size,
    input  logic            consume,
    output logic            can_send,
    output logic [RL_W-1:0] tokens
);

    logic [RL_W-1:0] r_period_cnt;
    logic [RL_W-1:0] r_tokens;

    logic            w_refill;
    logic            w_consume;
    logic            w_bypass;
    logic [RL_W:0]   w_sum;
    logic [RL_W:0]   w_tokens_nxt;

    always_comb begin
        w_bypass  = (size == '0);
        w_refill  = (r_period_cnt == period);
        w_consume = consume && !w_bypass;
        // One bit of headroom so refill on a nearly full bucket cannot wrap
        w_sum     = {1'b0, r_tokens} - {{RL_W{1'b0}}, w_consume}
                  + (w_refill ? {1'b0, inc} : '0);
        if (w_bypass) begin
            w_tokens_nxt = '0;
        end else if (w_sum > {1'b0, size}) begin
            w_tokens_nxt = {1'b0, size};
        end else begin
            w_tokens_nxt = w_sum;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_period_cnt <= '0;
            r_tokens     <= '0;
        end else begin
            r_period_cnt <= w_refill ? '0 : r_period_cnt + 1'b1;
            r_tokens     <= w_tokens_nxt[RL_W-1:0];
        end
    end

    assign can_send = w_bypass || (r_tokens != '0);
    assign tokens   = r_tokens;

endmodule

// File: rtl/net_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one TX stream between N_PORTS sources,
// with a zero-latency pass-through mux gated by a token-bucket limiter.
module net_tx_arbiter
    import net_tx_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int KEEP_W  = KEEP_W_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_PORTS-1:0]          in_valid,
    output logic [N_PORTS-1:0]          in_ready,
    input  logic [N_PORTS*DATA_W-1:0]   in_data,
    input  logic [N_PORTS*KEEP_W-1:0]   in_keep,
    input  logic [N_PORTS-1:0]          in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [KEEP_W-1:0]           out_keep,
    output logic                        out_last,
    input  logic [RL_W-1:0]             rlimit_inc,
    input  logic [RL_W-1:0]             rlimit_period,
    input  logic [RL_W-1:0]             rlimit_size,
    output logic [$clog2(N_PORTS)-1:0]  grant_id,
    output logic                        busy
);

    localparam int GW = $clog2(N_PORTS);

    arb_state_e      r_state;
    arb_state_e      w_state_nxt;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   w_grant_nxt;
    logic [GW-1:0]   r_rr_ptr;
    logic [GW-1:0]   w_rr_ptr_nxt;

    rl_cfg_t         w_rl_cfg;
    logic            w_can_send;
    logic [RL_W-1:0] w_tokens;
    logic            w_beat;
    logic            w_busy;
    logic            w_pick_found;
    logic [GW-1:0]   w_pick_idx;

    logic              w_sel_valid;
    logic [DATA_W-1:0] w_sel_data;
    logic [KEEP_W-1:0] w_sel_keep;
    logic              w_sel_last;

    // First requester at or after ptr, wrapping modulo N_PORTS; MSB = found
    function automatic logic [GW:0] rr_pick(input logic [N_PORTS-1:0] req,
                                            input logic [GW-1:0]      ptr);
        logic          found;
        logic [GW-1:0] idx;
        logic [GW:0]   cand;
        logic [GW-1:0] cand_idx;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = {1'b0, ptr} + (GW+1)'(k);
            if (cand >= (GW+1)'(N_PORTS)) begin
                cand = cand - (GW+1)'(N_PORTS);
            end
            cand_idx = cand[GW-1:0];
            if (!found && req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
        return {found, idx};
    endfunction

    assign w_rl_cfg = '{inc: rlimit_inc, period: rlimit_period, size: rlimit_size};

    net_token_bucket u_bucket (
        .clock    (clock),
        .reset    (reset),
        .inc      (w_rl_cfg.inc),
        .period   (w_rl_cfg.period),
        .size     (w_rl_cfg.size),
        .consume  (w_beat),
        .can_send (w_can_send),
        .tokens   (w_tokens)
    );

    assign {w_pick_found, w_pick_idx} = rr_pick(in_valid, r_rr_ptr);
    assign w_beat = out_valid && out_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_grant  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            IDLE: begin
                if (w_pick_found) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_idx;
                end
            end
            BURST: begin
                if (w_beat && w_sel_last) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = (r_grant == GW'(N_PORTS - 1)) ? '0 : r_grant + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (r_grant == GW'(i)) begin
                w_sel_valid = in_valid[i];
                w_sel_data  = in_data[i*DATA_W +: DATA_W];
                w_sel_keep  = in_keep[i*KEEP_W +: KEEP_W];
                w_sel_last  = in_last[i];
            end
        end

        w_busy    = (r_state == BURST);
        out_valid = w_busy && w_sel_valid && w_can_send;
        out_data  = w_busy ? w_sel_data : '0;
        out_keep  = w_busy ? w_sel_keep : '0;
        out_last  = w_busy && w_sel_last;

        for (int i = 0; i < N_PORTS; i++) begin
            in_ready[i] = w_busy && (r_grant == GW'(i)) && out_ready && w_can_send;
        end

        grant_id = r_grant;
        busy     = w_busy;
    end

endmodule

// File: tb/tb_net_tx_arbiter.sv
// Scoreboard bench for net_tx_arbiter: directed scenarios plus randomized traffic
// against a queue-based behavioural model of arbitration and rate limiting.
module tb_net_tx_arbiter;
    import net_tx_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int GW = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      in_valid;
    logic [N-1:0]      in_ready;
    logic [N*DW-1:0]   in_data;
    logic [N*KW-1:0]   in_keep;
    logic [N-1:0]      in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [KW-1:0]     out_keep;
    logic              out_last;
    logic [7:0]        rlimit_inc;
    logic [7:0]        rlimit_period;
    logic [7:0]        rlimit_size;
    logic [GW-1:0]     grant_id;
    logic              busy;

    always #5 clock = ~clock;

    net_tx_arbiter #(.N_PORTS(N), .DATA_W(DW), .KEEP_W(KW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_keep(in_keep), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_keep(out_keep), .out_last(out_last),
        .rlimit_inc(rlimit_inc), .rlimit_period(rlimit_period), .rlimit_size(rlimit_size),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          src;
    } beat_t;

    beat_t    src_q[N][$];
    beat_t    exp_q[$];
    int       dut_order[$];
    int       n_cmp = 0;
    int       n_err = 0;

    // reference model state
    bit       m_busy;
    int       m_g, m_ptr, m_tok, m_pc, cyc;
    int       first_hs_cyc, last_hs_cyc, max_tok;
    bit       dut_first;
    bit       gaps;
    int       ready_mode;
    int       hold_low;
    bit [N-1:0] hs_src;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            m_busy = 0; m_g = 0; m_ptr = 0; m_tok = 0; m_pc = 0; cyc = 0;
            exp_q.delete();
            hs_src = '0;
            dut_first = 1;
        end else begin
            bit can, e_ov, hs, refill, found;
            logic [N-1:0] e_ir;
            int t;
            beat_t b;
            can  = (rlimit_size == 0) || (m_tok != 0);
            e_ov = m_busy && in_valid[m_g] && can;
            e_ir = (m_busy && out_ready && can) ? (N'(1) << m_g) : '0;
            chk("out_valid", 64'(out_valid), 64'(e_ov));
            chk("in_ready", 64'(in_ready), 64'(e_ir));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("grant_id", 64'(grant_id), 64'(m_g));
            chk("rr_ptr", 64'(dut.r_rr_ptr), 64'(m_ptr));
            chk("tokens", 64'(dut.u_bucket.tokens), 64'(m_tok));
            if (!m_busy) chk("idle_out_zero", 64'({out_data, out_keep, out_last} != 0), 64'd0);
            if (int'(dut.u_bucket.tokens) > max_tok) max_tok = int'(dut.u_bucket.tokens);

            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_beat: got data %0h expected no beat", out_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("beat_data", out_data, b.data);
                    chk("beat_keep", 64'(out_keep), 64'(b.keep));
                    chk("beat_last", 64'(out_last), 64'(b.last));
                    chk("beat_src", 64'(grant_id), 64'(b.src));
                end
                if (dut_first) dut_order.push_back(int'(grant_id));
                dut_first = out_last;
                if (first_hs_cyc < 0) first_hs_cyc = cyc;
                last_hs_cyc = cyc;
            end
            for (int i = 0; i < N; i++) if (in_valid[i] && in_ready[i]) hs_src[i] = 1'b1;

            hs = e_ov && out_ready;
            if (m_busy) begin
                if (hs && in_last[m_g]) begin
                    m_busy = 0;
                    m_ptr  = (m_g + 1) % N;
                end
            end else begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (m_ptr + k) % N;
                    if (!found && in_valid[idx]) begin
                        found  = 1;
                        m_busy = 1;
                        m_g    = idx;
                        for (int j = 0; j < src_q[idx].size(); j++) begin
                            b = src_q[idx][j];
                            b.src = idx;
                            exp_q.push_back(b);
                            if (b.last) break;
                        end
                    end
                end
            end

            refill = (m_pc == int'(rlimit_period));
            m_pc   = refill ? 0 : m_pc + 1;
            if (rlimit_size == 0) begin
                m_tok = 0;
            end else begin
                t = m_tok - (hs ? 1 : 0) + (refill ? int'(rlimit_inc) : 0);
                m_tok = (t > int'(rlimit_size)) ? int'(rlimit_size) : t;
            end
            cyc++;
        end
    end

    task automatic drive_inputs();
        for (int i = 0; i < N; i++)
            if (hs_src[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        hs_src = '0;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && (!gaps || $urandom_range(0, 3) != 0)) begin
                in_valid[i]          = 1'b1;
                in_data[i*DW +: DW]  = src_q[i][0].data;
                in_keep[i*KW +: KW]  = src_q[i][0].keep;
                in_last[i]           = src_q[i][0].last;
            end else begin
                in_valid[i]          = 1'b0;
                in_data[i*DW +: DW]  = {$urandom, $urandom};
                in_keep[i*KW +: KW]  = 8'($urandom);
                in_last[i]           = 1'($urandom_range(0, 1));
            end
        end
        if (hold_low > 0) begin
            out_ready = 1'b0;
            hold_low--;
        end else if (ready_mode == 1) begin
            out_ready = ($urandom_range(0, 3) != 0);
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
        drive_inputs();
    endtask

    task automatic mk_pkt(input int src, input int len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = {$urandom, $urandom};
            b.keep = 8'($urandom);
            b.last = (k == len - 1);
            b.src  = src;
            src_q[src].push_back(b);
        end
    endtask

    task automatic apply_reset(input bit mid);
        @(posedge clock);
        #1;
        reset = 1'b0;
        if (mid) begin
            #1;
            chk("midrst_out_valid", 64'(out_valid), 64'd0);
            chk("midrst_in_ready", 64'(in_ready), 64'd0);
        end
        for (int i = 0; i < N; i++) src_q[i].delete();
        in_valid = '0;
        hs_src = '0;
        hold_low = 0;
        first_hs_cyc = -1;
        last_hs_cyc = -1;
        max_tok = 0;
        dut_order.delete();
        @(posedge clock);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b1;
        drive_inputs();
    endtask

    task automatic drain(input int budget);
        int n;
        bit pend;
        n = 0;
        forever begin
            pend = m_busy || (exp_q.size() != 0);
            for (int i = 0; i < N; i++) if (src_q[i].size() != 0) pend = 1;
            if (!pend || n >= budget) break;
            cycle();
            n++;
        end
        if (n >= budget) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: still pending after %0d cycles, expected empty", n);
        end
    endtask

    task automatic set_cfg(input int inc, input int period, input int size);
        rlimit_inc    = 8'(inc);
        rlimit_period = 8'(period);
        rlimit_size   = 8'(size);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        in_valid = '0; in_data = '0; in_keep = '0; in_last = '0;
        out_ready = 1'b1; gaps = 0; ready_mode = 0; hold_low = 0;
        first_hs_cyc = -1; last_hs_cyc = -1; max_tok = 0; cyc = 0;
        set_cfg(0, 0, 0);
        repeat (2) @(posedge clock);

        // Limiter off, one 3-beat packet on source 2
        apply_reset(0);
        mk_pkt(2, 3);
        release_reset();
        drain(200);
        chk("A_first_beat_cyc", 64'(first_hs_cyc), 64'd1);
        chk("A_last_beat_cyc", 64'(last_hs_cyc), 64'd3);
        chk("A_pkt_count", 64'(dut_order.size()), 64'd1);
        if (dut_order.size() > 0) chk("A_grant", 64'(dut_order[0]), 64'd2);
        chk("A_rr_ptr", 64'(dut.r_rr_ptr), 64'd3);

        // All sources with 2-beat packets, source 0 has a second packet
        apply_reset(0);
        for (int i = 0; i < N; i++) mk_pkt(i, 2);
        mk_pkt(0, 2);
        release_reset();
        drain(200);
        chk("B_pkt_count", 64'(dut_order.size()), 64'd5);
        for (int k = 0; k < 5 && k < dut_order.size(); k++)
            chk("B_order", 64'(dut_order[k]), 64'(k % N));
        chk("B_last_beat_cyc", 64'(last_hs_cyc), 64'd14);

        // out_ready low for 5 cycles mid-packet
        apply_reset(0);
        mk_pkt(1, 6);
        release_reset();
        cycle();
        cycle();
        hold_low = 5;
        drain(200);
        chk("C_last_beat_cyc", 64'(last_hs_cyc), 64'd11);

        // inc=1 period=3 size=2, 8-beat packet
        set_cfg(1, 3, 2);
        apply_reset(0);
        mk_pkt(0, 8);
        release_reset();
        drain(500);
        chk("D_first_beat_cyc", 64'(first_hs_cyc), 64'd4);
        chk("D_last_beat_cyc", 64'(last_hs_cyc), 64'd32);
        chk("D_tokens_over_cap", 64'(max_tok > 2), 64'd0);

        // Large refill into nearly full bucket must saturate, not wrap
        set_cfg(200, 0, 255);
        apply_reset(0);
        mk_pkt(1, 6);
        release_reset();
        drain(200);
        repeat (3) cycle();
        chk("E_tokens_sat", 64'(dut.u_bucket.tokens), 64'd255);

        // Reset mid-packet
        set_cfg(1, 0, 3);
        apply_reset(0);
        mk_pkt(3, 5);
        release_reset();
        repeat (4) cycle();
        apply_reset(1);
        release_reset();
        #1;
        chk("R_busy", 64'(busy), 64'd0);
        chk("R_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);
        chk("R_tokens", 64'(dut.u_bucket.tokens), 64'd0);
        repeat (3) cycle();

        // Randomized traffic and configuration
        for (int r = 0; r < 3; r++) begin
            set_cfg($urandom_range(1, 4), $urandom_range(0, 7),
                    ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 8));
            apply_reset(0);
            release_reset();
            gaps = 1;
            ready_mode = 1;
            repeat (250) begin
                if ($urandom_range(0, 5) == 0) mk_pkt($urandom_range(0, N - 1), $urandom_range(1, 4));
                cycle();
            end
            drain(4000);
            gaps = 0;
            ready_mode = 0;
        end

        repeat (2) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
